// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl -- memory self-test initiator for a single-port block RAM.
//
// Writes a selectable pattern to every RAM word, reads every word back and
// compares it with the expected value. It reports pass/fail, a mismatch count
// and the first failing address.
//
// Optional build macro: RAM_BIST_INV_PASS_EN
//   When this macro is defined, a second write/read pass follows the first
//   one. The second pass uses the inverted pattern, and err_count becomes one
//   bit wider.
//
// Ports:
//   clk            rising-edge system clock
//   rst_n          synchronous active-low reset
//   start          begin a test (sampled only while idle)
//   pattern_sel    0=address-derived, 1=checkerboard, 2=all-ones, 3=all-zeros
//   mem_we         RAM write enable
//   mem_addr       RAM address
//   mem_din        RAM write data
//   mem_dout       RAM read data (valid RD_LAT cycles after mem_addr)
//   busy           test in progress (write, read or drain phase)
//   done           one-cycle pulse at test end
//   pass           last test had no mismatches; held until the next start
//   err_count      number of mismatching words (saturating)
//   first_err_addr address of the first mismatch, 0 if none
module ram_bist_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
`ifdef RAM_BIST_INV_PASS_EN
  output logic [ADDR_W+1:0] err_count,
`else
  output logic [ADDR_W:0]   err_count,
`endif
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

`ifdef RAM_BIST_INV_PASS_EN
  localparam int ERR_W     = ADDR_W + 2;
  localparam int ERR_MAX_I = 1 << (ADDR_W + 1);
`else
  localparam int ERR_W     = ADDR_W + 1;
  localparam int ERR_MAX_I = 1 << ADDR_W;
`endif
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ERR_MAX_I);

  // Expected word for address a under pattern sel; inv selects the complement pass.
  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0] sel,
                                                 input logic inv);
    logic [DATA_W-1:0] e;
    case (sel)
      2'd0:    e = DATA_W'({a, ~a});
      2'd1:    e = a[0] ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
      2'd2:    e = '1;
      default: e = '0;
    endcase
    return inv ? ~e : e;
  endfunction

  logic [2:0]        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [1:0]        pat_q, pat_d;
  logic              inv_q, inv_d;
  logic [2:0]        drain_cnt_q, drain_cnt_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;

  // Read-compare pipeline: each read issue travels RD_LAT stages so that it
  // lines up with the matching mem_dout word.
  logic [RD_LAT-1:0]             pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr_q, pipe_addr_d;

  logic [ADDR_W-1:0] addr_inc;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;

  assign addr_inc = mem_addr_q + 1'b1;
  assign cmp_vld  = pipe_vld_q[RD_LAT-1];
  assign cmp_addr = pipe_addr_q[RD_LAT-1];
  assign mismatch = cmp_vld && (mem_dout != exp_data(cmp_addr, pat_q, inv_q));

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_vld_d[gi]  = (state_q == S_READ);
        assign pipe_addr_d[gi] = mem_addr_q;
      end else begin : g_tail
        assign pipe_vld_d[gi]  = pipe_vld_q[gi-1];
        assign pipe_addr_d[gi] = pipe_addr_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = '0;
    pat_d       = pat_q;
    inv_d       = inv_q;
    drain_cnt_d = drain_cnt_q;
    pass_d      = pass_q;
    err_d       = err_q;
    first_d     = first_q;

    // The compare runs whenever a pipeline entry retires. The IDLE start
    // branch below overrides these values, which is safe because the
    // pipeline is always empty in IDLE.
    if (mismatch) begin
      if (err_q == '0) first_d = cmp_addr;
      if (err_q != ERR_MAX) err_d = err_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        mem_addr_d = '0;
        if (start) begin
          pat_d     = pattern_sel;
          inv_d     = 1'b0;
          err_d     = '0;
          first_d   = '0;
          pass_d    = 1'b0;
          state_d   = S_WRITE;
          mem_we_d  = 1'b1;
          mem_din_d = exp_data('0, pattern_sel, 1'b0);
        end
      end
      S_WRITE: begin
        if (mem_addr_q == '1) begin
          state_d    = S_READ;
          mem_addr_d = '0;
        end else begin
          mem_addr_d = addr_inc;
          mem_we_d   = 1'b1;
          mem_din_d  = exp_data(addr_inc, pat_q, inv_q);
        end
      end
      S_READ: begin
        if (mem_addr_q == '1) begin
          state_d     = S_DRAIN;
          mem_addr_d  = '0;
          drain_cnt_d = '0;
        end else begin
          mem_addr_d = addr_inc;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == 3'(RD_LAT - 1)) begin
`ifdef RAM_BIST_INV_PASS_EN
          if (!inv_q) begin
            state_d    = S_WRITE;
            inv_d      = 1'b1;
            mem_addr_d = '0;
            mem_we_d   = 1'b1;
            mem_din_d  = exp_data('0, pat_q, 1'b1);
          end else begin
            state_d = S_DONE;
            pass_d  = (err_d == '0);
          end
`else
          state_d = S_DONE;
          // err_d already holds the final compare of this cycle.
          pass_d  = (err_d == '0);
`endif
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        mem_addr_d = '0;
      end
      default: begin
        state_d    = S_IDLE;
        mem_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      pat_q       <= '0;
      inv_q       <= 1'b0;
      drain_cnt_q <= '0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_q     <= '0;
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      pat_q       <= pat_d;
      inv_q       <= inv_d;
      drain_cnt_q <= drain_cnt_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_q     <= first_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
    end
  end

  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_din        = mem_din_q;
  assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl (default build).
//
// Two controller instances are used. Instance A runs with RD_LAT=1 and
// instance B runs with RD_LAT=3. Each instance drives its own RAM model with
// selectable faults. Each stimulus pushes the expected done-time result into
// a queue, and a monitor process pops and compares the queue entry on every
// done pulse.
module tb_ram_bist_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
`ifdef RAM_BIST_INV_PASS_EN
  localparam int EW = AW + 2;
`else
  localparam int EW = AW + 1;
`endif

  typedef struct {
    int cyc;
    int pass;
    int err;
    int first;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // ---------------- instance A: RD_LAT = 1 ----------------
  logic          start_a = 1'b0;
  logic [1:0]    sel_a = 2'd0;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a, dout_a;
  logic          busy_a, done_a, pass_a;
  logic [EW-1:0] err_a;
  logic [AW-1:0] first_a;
  int            fault_a = 0;  // 0 none, 1 bit3 stuck-0 at 0x10, 2 addr bit0 stuck-0

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pattern_sel(sel_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_din(din_a), .mem_dout(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_addr(first_a)
  );

  logic [DW-1:0] mem_a [256];
  logic [AW-1:0] ea;
  assign ea = (fault_a == 2) ? {addr_a[AW-1:1], 1'b0} : addr_a;
  always @(posedge clk) begin
    if (we_a) mem_a[ea] <= din_a;
    dout_a <= (fault_a == 1 && ea == 8'h10) ? (mem_a[ea] & ~16'h0008) : mem_a[ea];
  end

  // ---------------- instance B: RD_LAT = 3 ----------------
  logic          start_b = 1'b0;
  logic [1:0]    sel_b = 2'd0;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] din_b, dout_b;
  logic          busy_b, done_b, pass_b;
  logic [EW-1:0] err_b;
  logic [AW-1:0] first_b;
  int            lat_b = 3;
  logic [DW-1:0] rdp_b [3];

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pattern_sel(sel_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_din(din_b), .mem_dout(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_addr(first_b)
  );

  logic [DW-1:0] mem_b [256];
  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= din_b;
    rdp_b[0] <= mem_b[addr_b];
    rdp_b[1] <= rdp_b[0];
    rdp_b[2] <= rdp_b[1];
  end
  assign dout_b = rdp_b[lat_b-1];

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_a) begin
      if (q_a.size() == 0) begin
        check("A unexpected done", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("A done cycle", cyc, e.cyc);
        check("A pass", int'(pass_a), e.pass);
        check("A err_count", int'(err_a), e.err);
        check("A first_err_addr", int'(first_a), e.first);
        $display("A done @%0d pass=%0d err=%0d first=0x%0h", cyc, pass_a, err_a, first_a);
      end
    end
    if (rst_n && done_b) begin
      if (q_b.size() == 0) begin
        check("B unexpected done", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("B done cycle", cyc, e.cyc);
        check("B pass", int'(pass_b), e.pass);
        check("B err_count", int'(err_b), e.err);
        check("B first_err_addr", int'(first_b), e.first);
        $display("B done @%0d pass=%0d err=%0d first=0x%0h", cyc, pass_b, err_b, first_b);
      end
    end
  end

  // Pulse start on A for one cycle and queue the expected result. Returns one cycle later.
  task automatic issue_a(input int sel, input int fault, input int lat_cyc,
                         input int p, input int e, input int f);
    exp_t x;
    fault_a = fault;
    sel_a   = 2'(sel);
    start_a = 1'b1;
    x.cyc = cyc + lat_cyc; x.pass = p; x.err = e; x.first = f;
    q_a.push_back(x);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic issue_b(input int sel, input int lat, input int p, input int e, input int f);
    exp_t x;
    lat_b   = lat;
    sel_b   = 2'(sel);
    start_b = 1'b1;
    x.cyc = cyc + 516; x.pass = p; x.err = e; x.first = f;
    q_b.push_back(x);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 3000 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      check("done timeout", q_a.size() + q_b.size(), 0);
      q_a.delete();
      q_b.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset mem_we", int'(we_a), 0);
    check("reset mem_addr", int'(addr_a), 0);
    check("reset busy", int'(busy_a), 0);
    check("reset done", int'(done_a), 0);
    check("reset pass", int'(pass_a), 0);
    check("reset err_count", int'(err_a), 0);
    check("reset first_err_addr", int'(first_a), 0);
    check("reset B busy", int'(busy_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal RAM, address-derived pattern; spot-check write data at 0x12.
    issue_a(0, 0, 514, 1, 0, 0);
    repeat (8'h12) @(negedge clk);
    check("write mem_we @0x12", int'(we_a), 1);
    check("write mem_addr @0x12", int'(addr_a), 8'h12);
    check("write mem_din @0x12", int'(din_a), 16'h12ED);
    wait_empty();

    // Bit 3 stuck at 0 at 0x10, all-ones.
    issue_a(2, 1, 514, 0, 1, 8'h10);
    wait_empty();
    repeat (3) @(negedge clk);
    check("pass held in idle", int'(pass_a), 0);
    check("err held in idle", int'(err_a), 1);

    // Address bit 0 stuck at 0: checkerboard fails on even addresses, zeros passes.
    issue_a(1, 2, 514, 0, 128, 0);
    wait_empty();
    issue_a(3, 2, 514, 1, 0, 0);
    wait_empty();

    // RD_LAT=3 with a matching model, then with a model one cycle too fast.
    issue_b(0, 3, 1, 0, 0);
    wait_empty();
    issue_b(0, 2, 0, 256, 0);
    wait_empty();

    // Reset during WRITE at address 0x40.
    fault_a = 0;
    sel_a   = 2'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (8'h40) @(negedge clk);
    check("mid-test addr before reset", int'(addr_a), 8'h40);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("after reset mem_we", int'(we_a), 0);
    check("after reset busy", int'(busy_a), 0);
    check("after reset err_count", int'(err_a), 0);
    @(negedge clk);
    issue_a(0, 0, 514, 1, 0, 0);
    wait_empty();

    // Start ignored while busy and in DONE; accepted right after, in IDLE.
    issue_a(3, 1, 514, 1, 0, 0);          // start sampled in cycle N, now at N+1
    repeat (99) @(negedge clk);           // cycle N+100
    start_a = 1'b1;
    sel_a   = 2'd2;
    @(negedge clk);
    start_a = 1'b0;
    repeat (413) @(negedge clk);          // cycle N+514 (DONE)
    start_a = 1'b1;
    @(negedge clk);                       // cycle N+515 (IDLE): accepted
    begin
      exp_t x;
      x.cyc = cyc + 514; x.pass = 0; x.err = 1; x.first = 8'h10;
      q_a.push_back(x);
    end
    @(negedge clk);
    start_a = 1'b0;
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Self-test initiator that drives the 256x16 single-port block-RAM wrapper from the requester side.
- Writes a selectable data pattern to every address, reads every address back, and compares each word against the expected value.
- Reports a pass/fail result, an error count and the first failing address.
- Sits in the hardware-tester area. Its mem_* ports connect directly to the RAM wrapper's we/addr/din/dout.

Parameters:
- ADDR_W, 8, RAM address width; the test covers 2^ADDR_W words.
- DATA_W, 16, RAM data width; must be even and >= 2*ADDR_W.
- RD_LAT, 1, RAM read latency in cycles, from addr presented to dout valid; legal range 1..4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin test; sampled only in IDLE.
- pattern_sel  input  2  0=address-derived, 1=checkerboard, 2=all-ones, 3=all-zeros; latched when start is accepted.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_din  output  DATA_W  RAM write data.
- mem_dout  input  DATA_W  RAM read data.
- busy  output  1  high in WRITE, READ and DRAIN.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  1 when the last test had err_count==0; held until the next accepted start.
- err_count  output  ADDR_W+1  number of mismatching words.
- first_err_addr  output  ADDR_W  address of the first mismatch; 0 if there was none.

Behaviour:
- Reset: applies when rst_n is low at a clk edge.
  - State returns to IDLE.
  - mem_we, mem_addr, mem_din, busy, done, pass, err_count, first_err_addr and all pipeline valid bits are 0.
  - Reset mid-test aborts immediately; mem_we is 0 from the next edge.
- Expected data E(a) for address a:
  - sel 0: {a, ~a}, zero-extended at the MSB to DATA_W.
  - sel 1: a[0] ? 16'h5555 : 16'hAAAA, replicated to DATA_W.
  - sel 2: all ones.
  - sel 3: all zeros.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - Outputs idle, with mem_we=0 and mem_addr=0.
  - If start=1: latch pattern_sel, clear err_count/first_err_addr/pass, go to WRITE with mem_addr=0.
- WRITE:
  - mem_we=1, mem_din=E(mem_addr); mem_addr increments each cycle.
  - After address 2^ADDR_W-1 is written, go to READ with mem_addr=0 and mem_we=0.
- READ:
  - mem_we=0; mem_addr increments each cycle.
  - Each issued address enters an RD_LAT-deep pipeline of {valid, addr}.
  - After the last address is issued, go to DRAIN.
- Compare: in the cycle a pipeline entry emerges valid, mem_dout is compared with E(addr).
  - On mismatch: err_count increments.
  - first_err_addr is written only on the first mismatch.
  - err_count cannot overflow; its maximum value is 2^ADDR_W.
- DRAIN: lasts RD_LAT cycles, retiring the remaining compares, then goes to DONE.
- DONE: done=1 for one cycle, pass=(err_count==0), then return to IDLE.
- Timing: with start sampled at cycle 0, done is high in cycle 2*2^ADDR_W + RD_LAT + 1 (514 at the defaults).
- start while busy or in DONE is ignored. pattern_sel changes after start are ignored.
- Address wrap: mem_addr never wraps mid-phase; it is reloaded to 0 at each phase transition.
- err_count and first_err_addr hold their values in IDLE until the next accepted start.

Optional Feature:
- Macro RAM_BIST_INV_PASS_EN.
- When defined:
  - After DRAIN, run a second WRITE/READ/DRAIN sequence using ~E(a).
  - Errors from both passes accumulate; err_count widens to ADDR_W+2.
  - first_err_addr records the first mismatch from either pass.
  - done occurs at cycle 4*2^ADDR_W + 2*RD_LAT + 1.
- When undefined: single pass only, with the widths and timing given above.

Test Plan:
- Ideal RAM model with RD_LAT=1, sel=0, start at cycle 0: done at cycle 514, pass=1, err_count=0, first_err_addr=0. mem_din at address 0x12 is 16'h12ED.
- RAM model with bit 3 stuck at 0 at address 0x10 only, sel=2: pass=0, err_count=1, first_err_addr=0x10.
- Address line 0 stuck at 0 (0x01 aliases 0x00), sel=1: err_count=128, first_err_addr=0x00. Same fault with sel=3: pass=1.
- RD_LAT=3 with a matching model, sel=0: done at cycle 516 and pass=1. The model shifted to RD_LAT=2 gives err_count=256.
- rst_n low for one cycle during WRITE at address 0x40: next cycle state is IDLE and mem_we/busy/err_count are 0. A fresh start then completes normally.
- start pulsed at cycles 100 and 514 of a running test: no restart and exactly one done. A start at cycle 515 (IDLE) is accepted.
